// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle carrying one payload word per transfer.
//   valid : producer offers data this cycle
//   data  : payload, WIDTH bits
//   ready : consumer can take the payload this cycle
// master drives valid/data, slave drives ready.
interface pipe_stage_if #(
  parameter int unsigned WIDTH = 96
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage.sv
// Two-entry skid-buffer pipeline stage with flush and performance counters.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   flush      : synchronous kill of held entries (input offered that cycle is dropped)
//   clr_cnt    : synchronous clear of both counters
//   up         : upstream handshake (up.ready is the stage's in_ready)
//   dn         : downstream handshake (dn.data is the head entry, NOP when empty)
//   occ        : number of entries held (0..2)
//   stall_cnt  : saturating count of cycles with a valid head and no downstream ready
//   flush_cnt  : saturating count of flushes that killed at least one entry
// All outputs come straight from flops; out_ready never reaches in_ready combinationally.
module pipe_stage #(
  parameter int unsigned      WIDTH = 96,
  parameter logic [WIDTH-1:0] NOP   = '0,
  parameter int unsigned      CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                clr_cnt,
  pipe_stage_if.slave         up,
  pipe_stage_if.master        dn,
  output logic [1:0]          occ,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept;
  logic             drain;

  assign accept   = up.valid & in_ready_q;
  assign drain    = out_valid_q & dn.ready;

  assign up.ready = in_ready_q;
  assign dn.valid = out_valid_q;
  assign dn.data  = main_q;
  assign occ      = 2'(state);

  // Next-state and datapath selection; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = NOP;
      skid_nxt  = NOP;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            main_nxt  = up.data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_nxt  = up.data;
          end else if (accept) begin
            state_nxt = TWO;
            skid_nxt  = up.data;
          end else if (drain) begin
            state_nxt = EMPTY;
            main_nxt  = NOP;
          end
        end
        TWO: begin
          if (drain) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
            skid_nxt  = NOP;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = NOP;
          skid_nxt  = NOP;
        end
      endcase
    end
  end

  // State, payload and handshake flags; flags are precomputed from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      main_q      <= NOP;
      skid_q      <= NOP;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      main_q      <= main_nxt;
      skid_q      <= skid_nxt;
      in_ready_q  <= (state_nxt != TWO);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid_q && !dn.ready && !flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (state != EMPTY) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed vector table, randomized traffic
// against a queue-based reference model, and hand-written corner sequences.
module tb_pipe_stage;

  localparam int unsigned WIDTH = 96;
  localparam int unsigned CNT_W = 4;
  localparam int          SAT   = (1 << CNT_W) - 1;
  localparam logic [WIDTH-1:0] NOP_V = 96'h0BAD_F00D_0BAD_F00D_0BAD_F00D;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             clr_cnt;
  logic [1:0]       occ;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipe_stage_if #(.WIDTH(WIDTH)) up_if ();
  pipe_stage_if #(.WIDTH(WIDTH)) dn_if ();

  pipe_stage #(.WIDTH(WIDTH), .NOP(NOP_V), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .clr_cnt   (clr_cnt),
    .up        (up_if.slave),
    .dn        (dn_if.master),
    .occ       (occ),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: FIFO of held entries plus plain integer counters.
  logic [WIDTH-1:0] mq[$];
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic [WIDTH-1:0] pat(input int n);
    return {3{32'(n)}};
  endfunction

  task automatic cmp(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_stall = 0;
    m_flush = 0;
  endtask

  // Apply one cycle of inputs, advance the model across the edge, sample at edge+1.
  task automatic cycle(input bit iv, input logic [WIDTH-1:0] d, input bit ordy,
                       input bit fl, input bit clr);
    int  sz;
    bit  acc, drn;
    up_if.valid = iv;
    up_if.data  = d;
    dn_if.ready = ordy;
    flush       = fl;
    clr_cnt     = clr;
    @(posedge clk);
    sz  = mq.size();
    acc = iv && (sz < 2);
    drn = (sz > 0) && ordy;
    if (clr) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (sz > 0 && !ordy && !fl && m_stall < SAT) m_stall++;
      if (fl && sz > 0 && m_flush < SAT) m_flush++;
    end
    if (fl) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    cmp({tag, ".occ"},       WIDTH'(occ),          WIDTH'(sz));
    cmp({tag, ".out_valid"}, WIDTH'(dn_if.valid),  WIDTH'(sz > 0));
    cmp({tag, ".in_ready"},  WIDTH'(up_if.ready),  WIDTH'(sz < 2));
    cmp({tag, ".out_data"},  dn_if.data,           (sz > 0) ? mq[0] : NOP_V);
    cmp({tag, ".stall_cnt"}, WIDTH'(stall_cnt),    WIDTH'(m_stall));
    cmp({tag, ".flush_cnt"}, WIDTH'(flush_cnt),    WIDTH'(m_flush));
  endtask

  task automatic check_reset_state(input string tag);
    cmp({tag, ".occ"},       WIDTH'(occ),         '0);
    cmp({tag, ".out_valid"}, WIDTH'(dn_if.valid), '0);
    cmp({tag, ".in_ready"},  WIDTH'(up_if.ready), WIDTH'(1));
    cmp({tag, ".out_data"},  dn_if.data,          NOP_V);
    cmp({tag, ".stall_cnt"}, WIDTH'(stall_cnt),   '0);
    cmp({tag, ".flush_cnt"}, WIDTH'(flush_cnt),   '0);
  endtask

  // Synchronous-looking reset pulse placed between edges.
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1 model_reset();
    check_reset_state("reset");
    #1 reset = 1'b0;
  endtask

  typedef struct {
    bit               iv;
    logic [WIDTH-1:0] d;
    bit               ordy;
    bit               fl;
    bit               clr;
    int               occ;
    logic [WIDTH-1:0] data;
    int               stall;
    int               flc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    clr_cnt     = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;

    // Reset holds state regardless of clock edges.
    #3 check_reset_state("por");
    up_if.valid = 1'b1;
    up_if.data  = pat(99);
    repeat (2) @(posedge clk);
    #1 check_reset_state("por_clk");
    up_if.valid = 1'b0;
    #1 reset = 1'b0;
    model_reset();

    // Streaming then backpressure, expected values worked out by hand.
    tbl[0] = '{1, pat(1),  1, 0, 0, 1, pat(1),  0, 0};
    tbl[1] = '{1, pat(2),  1, 0, 0, 1, pat(2),  0, 0};
    tbl[2] = '{1, pat(3),  1, 0, 0, 1, pat(3),  0, 0};
    tbl[3] = '{0, pat(0),  1, 0, 0, 0, NOP_V,   0, 0};
    tbl[4] = '{1, pat(10), 0, 0, 0, 1, pat(10), 0, 0};
    tbl[5] = '{1, pat(11), 0, 0, 0, 2, pat(10), 1, 0};
    tbl[6] = '{0, pat(0),  0, 0, 0, 2, pat(10), 2, 0};
    tbl[7] = '{0, pat(0),  1, 0, 0, 1, pat(11), 2, 0};
    tbl[8] = '{0, pat(0),  1, 0, 0, 0, NOP_V,   2, 0};
    tbl[9] = '{0, pat(0),  0, 0, 1, 0, NOP_V,   0, 0};
    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].clr);
      cmp({t, ".occ"},       WIDTH'(occ),         WIDTH'(tbl[i].occ));
      cmp({t, ".out_valid"}, WIDTH'(dn_if.valid), WIDTH'(tbl[i].occ != 0));
      cmp({t, ".in_ready"},  WIDTH'(up_if.ready), WIDTH'(tbl[i].occ != 2));
      cmp({t, ".out_data"},  dn_if.data,          tbl[i].data);
      cmp({t, ".stall_cnt"}, WIDTH'(stall_cnt),   WIDTH'(tbl[i].stall));
      cmp({t, ".flush_cnt"}, WIDTH'(flush_cnt),   WIDTH'(tbl[i].flc));
    end

    // Flush while two entries held: offered C is dropped, one flush counted.
    do_reset();
    cycle(1, pat(20), 0, 0, 0);
    cycle(1, pat(21), 0, 0, 0);
    cmp("two.occ", WIDTH'(occ), WIDTH'(2));
    cycle(1, pat(22), 0, 1, 0);
    cmp("flush_two.occ",   WIDTH'(occ),       '0);
    cmp("flush_two.data",  dn_if.data,        NOP_V);
    cmp("flush_two.count", WIDTH'(flush_cnt), WIDTH'(1));
    for (int i = 0; i < 3; i++) begin
      cycle(0, pat(0), 1, 0, 0);
      cmp("flush_two.no_c", WIDTH'(dn_if.valid), '0);
    end

    // Flush on an empty stage is not counted.
    cycle(0, pat(0), 1, 1, 0);
    cmp("flush_empty.count", WIDTH'(flush_cnt), WIDTH'(1));
    cmp("flush_empty.occ",   WIDTH'(occ),       '0);
    check_model("flush_empty");

    // Drain coincident with flush: head leaves, nothing remains.
    cycle(1, pat(30), 0, 0, 0);
    cycle(0, pat(0), 1, 1, 0);
    check_model("drain_flush");

    // Stall counter saturation and clear.
    do_reset();
    cycle(1, pat(40), 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, pat(0), 0, 0, 0);
    cmp("sat.stall_cnt", WIDTH'(stall_cnt), WIDTH'(15));
    cmp("sat.out_data",  dn_if.data,        pat(40));
    cycle(0, pat(0), 0, 0, 1);
    cmp("clr.stall_cnt", WIDTH'(stall_cnt), '0);
    cmp("clr.out_data",  dn_if.data,        pat(40));
    check_model("clr");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), {$urandom, $urandom, $urandom},
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 49) == 0));
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset between edges while full.
    dn_if.ready = 1'b0;
    cycle(1, pat(50), 0, 0, 0);
    cycle(1, pat(51), 0, 0, 0);
    cycle(1, pat(52), 0, 0, 0);
    cmp("pre_async.occ", WIDTH'(occ), WIDTH'(2));
    #2 reset = 1'b1;
    #1 check_reset_state("async");
    model_reset();
    #1 reset = 1'b0;

    // First edge after reset release accepts.
    cycle(1, pat(60), 0, 0, 0);
    cmp("post_reset.occ",  WIDTH'(occ), WIDTH'(1));
    cmp("post_reset.data", dn_if.data,  pat(60));
    check_model("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
